// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one BLOCK-bit lookahead group resolved per stage, valid/ready stream.
// Optional macro CLA_PIPE_SUB_EN adds an in_sub port that turns the beat into A - B - in_cin.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CLA_PIPE_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NBLK = WIDTH / BLOCK;

  // Two-level lookahead: c[i+1] = g[i] | OR_j (g[j] & p[j+1..i]) | (c0 & p[0..i])
  function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] g,
                                               input logic [BLOCK-1:0] p,
                                               input logic c0);
    logic [BLOCK:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < BLOCK; i++) begin
      term = c0;
      for (int t = 0; t <= i; t++) term = term & p[t];
      c[i+1] = g[i] | term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int t = j + 1; t <= i; t++) term = term & p[t];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef CLA_PIPE_SUB_EN
  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_cin ^ in_sub;
`else
  assign b_eff   = in_b;
  assign cin_eff = in_cin;
`endif

  // w_reg carries operand A rotated right one block per stage, with the finished
  // sum group rotated in at the top; after NBLK stages it holds the whole sum.
  logic             v_reg [NBLK];
  logic [WIDTH-1:0] w_reg [NBLK];
  logic [WIDTH-1:0] b_reg [NBLK];
  logic             c_reg [NBLK];
  logic             ovf_reg;

  logic             v_src [NBLK];
  logic             c_src [NBLK];
  logic [WIDTH-1:0] w_src [NBLK];
  logic [WIDTH-1:0] b_src [NBLK];

  logic [WIDTH-1:0] w_next [NBLK];
  logic [WIDTH-1:0] b_next [NBLK];
  logic             c_next [NBLK];
  logic             ovf_next;

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = v_reg[NBLK-1];
  assign out_sum   = w_reg[NBLK-1];
  assign out_cout  = c_reg[NBLK-1];
  assign out_ovf   = ovf_reg;

  always_comb begin
    v_src[0] = in_valid;
    w_src[0] = in_a;
    b_src[0] = b_eff;
    c_src[0] = cin_eff;
    for (int k = 1; k < NBLK; k++) begin
      v_src[k] = v_reg[k-1];
      w_src[k] = w_reg[k-1];
      b_src[k] = b_reg[k-1];
      c_src[k] = c_reg[k-1];
    end
  end

  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_stage
      logic [BLOCK-1:0] g_blk;
      logic [BLOCK-1:0] p_blk;
      logic [BLOCK-1:0] s_blk;
      logic [BLOCK:0]   c_blk;

      assign g_blk = w_src[gi][BLOCK-1:0] & b_src[gi][BLOCK-1:0];
      assign p_blk = w_src[gi][BLOCK-1:0] ^ b_src[gi][BLOCK-1:0];
      assign c_blk = lookahead(g_blk, p_blk, c_src[gi]);
      assign s_blk = p_blk ^ c_blk[BLOCK-1:0];

      assign w_next[gi] = (w_src[gi] >> BLOCK) | (WIDTH'(s_blk) << (WIDTH - BLOCK));
      assign b_next[gi] = (b_src[gi] >> BLOCK) | (b_src[gi] << (WIDTH - BLOCK));
      assign c_next[gi] = c_blk[BLOCK];

      if (gi == NBLK - 1) begin : g_last
        assign ovf_next = c_blk[BLOCK] ^ c_blk[BLOCK-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NBLK; k++) begin
        v_reg[k] <= 1'b0;
        w_reg[k] <= '0;
        b_reg[k] <= '0;
        c_reg[k] <= 1'b0;
      end
      ovf_reg <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NBLK; k++) begin
        v_reg[k] <= v_src[k];
        w_reg[k] <= w_next[k];
        b_reg[k] <= b_next[k];
        c_reg[k] <= c_next[k];
      end
      ovf_reg <= ovf_next;
    end
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder. Successor to the fixed 5-bit combinational CLA.
- The WIDTH-bit add is split into NBLK = WIDTH/BLOCK lookahead groups, with one group resolved per pipeline stage.
- Uses a valid/ready stream interface with full back-pressure.
- Sits between operand-issue logic and the datapath writeback in wide arithmetic units, where a single-cycle ripple or flat CLA misses timing.

Parameters:
- WIDTH, 32, operand and sum width in bits. Must be a multiple of BLOCK.
- BLOCK, 4, bits per lookahead group, which is also bits resolved per stage. Legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  adder can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  sum, registered.
- out_cout  output  1  carry out of the MSB, registered.
- out_ovf  output  1  two's-complement overflow, registered.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All stage valid bits clear; out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - Any in-flight beats are discarded, not completed.
  - in_ready=1 from the first cycle after reset deasserts.
- Pipeline advance: adv = out_ready | ~out_valid. All stages shift together when adv=1 and hold otherwise.
- Handshake:
  - in_ready = adv; this is a combinational path from out_ready.
  - A beat is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
  - Bubbles propagate as valid=0 and are dropped at the output when adv=1.
- Stage k (k=0..NBLK-1) for bits [k*BLOCK +: BLOCK]:
  - Compute G=a&b and P=a^b.
  - Compute the in-group carries with full two-level lookahead equations, not ripple, from the registered carry-in of that stage.
  - Produce sum bits S[i]=P[i]^c[i] and the group carry-out.
- Stage registers hold:
  - the lower sum bits produced so far;
  - the group carry-out;
  - the not-yet-processed upper operand bits (skew registers).
- Stage 0 uses in_cin as its carry-in.
- Latency: exactly NBLK cycles from accept to out_valid with no stall. Throughput is 1 beat/cycle when out_ready=1.
- out_cout is the carry out of bit WIDTH-1.
- out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Boundary cases:
  - Stall with all stages full: in_ready=0; no beat is lost or duplicated; order is preserved.
  - out_ready dropping while out_valid=1: out_sum, out_cout and out_ovf stay stable until consumed.
  - Accept and consume in the same cycle: both occur.
  - in_valid=0 while adv=1: a bubble is inserted.
  - NBLK=1: single registered stage with latency 1.
- X on operands with in_valid=0 must not propagate into any valid bit.

Optional Feature:
- Macro: CLA_PIPE_SUB_EN.
- Defined:
  - Adds port in_sub (input, 1), sampled with each beat.
  - When in_sub=1, B is replaced by ~in_b and the effective carry-in is ~in_cin, giving A - B - in_cin with in_cin acting as borrow-in.
  - out_cout=1 means no borrow.
  - out_ovf is computed from the effective operands.
- Undefined: no in_sub port; add only.

Test Plan:
- WIDTH=32, BLOCK=4: A=0xFFFFFFFF, B=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0, out_valid exactly 8 cycles after accept.
- A=0x7FFFFFFF, B=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. A=0x80000000, B=0x80000000 -> sum=0, cout=1, ovf=1.
- 20 back-to-back random beats, out_ready held low for 3 cycles mid-stream -> in_ready=0 while stalled and full, all 20 results in order and matching a reference model, outputs stable during the stall.
- rst pulsed for 1 cycle with 5 beats in flight -> out_valid=0 the next cycle, no stale result ever emitted, and a fresh beat afterwards completes in 8 cycles.
- CLA_PIPE_SUB_EN: 5-3 (cin=0) -> 0x00000002, cout=1; 3-5 -> 0xFFFFFFFE, cout=0; 0x80000000-1 -> 0x7FFFFFFF, ovf=1.
- WIDTH=5, BLOCK=5 and WIDTH=8, BLOCK=1: exhaustive A, B and cin -> every result matches A+B+cin, with latency 1 and 8 respectively.
